seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Receiver for the multiplexed 6-digit 7-segment bus driven by the display scanner: i_seg, i_seg_dp and active-low one-hot i_seg_enb.
- Samples each scanned digit once it has settled and rebuilds the full frame. Decodes the segment patterns back to BCD and reports minutes and seconds in binary.
- Used as a loopback checker in the clock testbench, and on a second board that mirrors the time display.

Parameters:
- SETTLE_CYC, 16: clk cycles i_seg_enb must hold the same legal value before that digit is sampled.
- TIMEOUT_CYC, 65536: clk cycles with no enable change before the bus is declared stale.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- i_seg  input  7  segment pattern {a,b,c,d,e,f,g}, 1 = lit.
- i_seg_dp  input  1  decimal point of the enabled digit.
- i_seg_enb  input  6  digit enables, active-low one-hot; bit 0 is the rightmost digit.
- o_min  output  6  decoded minutes, binary 0-59.
- o_sec  output  6  decoded seconds, binary 0-59.
- o_dp  output  6  captured decimal points, bit k = digit k.
- o_frame_valid  output  1  one-cycle pulse when o_min, o_sec and o_dp update.
- o_frame_err  output  1  one-cycle pulse when a frame is discarded.
- o_stale  output  1  level; bus inactive for TIMEOUT_CYC cycles.

Behaviour:
- Reset values:
  - o_min = 0, o_sec = 0, o_dp = 0.
  - o_frame_valid = 0, o_frame_err = 0, o_stale = 0.
  - FSM = SYNC; internal digit registers, seen mask and counters cleared.
- Reset can assert mid-frame; the partial frame is dropped with no pulse.
- Input synchronisation:
  - All 14 inputs pass through a 2-flop synchroniser; all logic below acts on the synchronised copies.
  - Input-to-sample latency is 2 + SETTLE_CYC cycles.
- Settle counter:
  - Clears whenever the synchronised enb differs from its value one cycle earlier.
  - Saturates at SETTLE_CYC.
  - When it reaches SETTLE_CYC with enb legal (exactly one bit 0), that digit index k is "sampled" exactly once per enable dwell.
  - An enb of all ones (blank) or with more than one zero is ignored for sampling; it does not raise an error.
- FSM states:
  - SYNC: wait for a sample with k = 0. Then store the digit, set seen = 000001, set next = 1, and go to COLLECT.
  - COLLECT, sample with k == next: store seg/dp into slot k, set the seen bit, then next++.
  - COLLECT, sample with k != next: pulse o_frame_err for 1 cycle and go to SYNC. If k == 0, it restarts directly as in SYNC.
  - COLLECT, sample with k == 5: go to EMIT.
  - EMIT (1 cycle): decode and check the frame.
    - Valid frame: update outputs and pulse o_frame_valid. Outputs therefore change 1 cycle after the digit-5 sample edge.
    - Invalid frame: pulse o_frame_err and leave outputs unchanged.
    - Either way, return to SYNC.
- Segment decode, pattern to BCD:
  - 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 73=9.
  - 00 = blank. Any other pattern is illegal.
- Frame validity rules:
  - Digits 0-3 must decode to 0-9.
  - Digits 4 and 5 must be blank.
  - Tens digits (1 and 3) must be <= 5.
- Arithmetic:
  - o_sec = d1*10 + d0, o_min = d3*10 + d2.
  - Computed in 7 bits and truncated to 6; the maximum is 59.
- Stale timeout:
  - An idle counter clears on any enb change and saturates at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC: o_stale = 1 and FSM = SYNC. Outputs hold their last values.
  - o_stale clears on the next o_frame_valid.
- Priority when events coincide: rst > timeout > sample > EMIT completion.

Optional Feature:
- SEG_SCAN_CAPTURE_DOUBLE_CHECK_EN
- Defined: a valid frame updates outputs only if its 4 decoded digits and o_dp equal the previous valid frame; otherwise the candidate is stored and no pulse is issued. A mismatch is not an error. After reset or stale, the first frame is stored only.
- Undefined: every valid frame updates outputs immediately.

Test Plan:
- Scan "12:34" with dp = 000010, 5000-cycle dwell per digit -> o_frame_valid once per scan; o_min = 12, o_sec = 34, o_dp = 000010, o_frame_err = 0.
- Scan digit order 0, 1, 3 -> o_frame_err pulse at the digit-3 sample; outputs keep their previous value; the next clean scan of 59:59 -> o_min = 59, o_sec = 59.
- Digit 2 pattern 7'h01 (illegal) -> o_frame_err in EMIT, no o_frame_valid; a digit 1 showing "7" (tens > 5) -> same result.
- Enb glitch shorter than SETTLE_CYC (8 cycles on digit 3 inside digit 2's dwell) -> no sample, no error; the frame decodes correctly.
- Hold enb constant for 65536 cycles -> o_stale = 1. A following clean "00:00" scan -> o_frame_valid, o_stale = 0, o_min = 0, o_sec = 0.
- Assert rst during COLLECT after digit 2 -> all outputs 0, no pulse; with SEG_SCAN_CAPTURE_DOUBLE_CHECK_EN defined, two identical "08:15" scans are needed before o_min = 8, o_sec = 15.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Receiver for the multiplexed 6-digit 7-segment bus: samples settled digits, rebuilds the frame,
// decodes MM:SS. Optional SEG_SCAN_CAPTURE_DOUBLE_CHECK_EN requires two identical frames per update.
module seg_scan_capture #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_seg,
  input  logic       i_seg_dp,
  input  logic [5:0] i_seg_enb,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [5:0] o_dp,
  output logic       o_frame_valid,
  output logic       o_frame_err,
  output logic       o_stale
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] IDLE_MAX    = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] IDLE_LAST   = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] SYNC    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;

  logic [6:0]    seg_m, seg_s;
  logic          dp_m, dp_s;
  logic [5:0]    enb_m, enb_s, enb_d;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] idle_cnt;
  logic          changed, legal, sample, timeout;
  logic [2:0]    k;

  logic [1:0]    state;
  logic [2:0]    next_k;
  logic [5:0]    seen;
  logic [6:0]    seg_q [0:5];
  logic [5:0]    dp_q;

  logic [5:0]    dec [0:3];
  logic          frame_ok;
  logic [6:0]    sec_w, min_w;

  // Decoded digit: {legal, blank, bcd}
  function automatic logic [5:0] seg_dec(input logic [6:0] p);
    case (p)
      7'h7E:   seg_dec = {2'b10, 4'd0};
      7'h30:   seg_dec = {2'b10, 4'd1};
      7'h6D:   seg_dec = {2'b10, 4'd2};
      7'h79:   seg_dec = {2'b10, 4'd3};
      7'h33:   seg_dec = {2'b10, 4'd4};
      7'h5B:   seg_dec = {2'b10, 4'd5};
      7'h5F:   seg_dec = {2'b10, 4'd6};
      7'h70:   seg_dec = {2'b10, 4'd7};
      7'h7F:   seg_dec = {2'b10, 4'd8};
      7'h73:   seg_dec = {2'b10, 4'd9};
      7'h00:   seg_dec = {2'b11, 4'd0};
      default: seg_dec = 6'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_m <= '0; seg_s <= '0;
      dp_m  <= 1'b0; dp_s <= 1'b0;
      enb_m <= '1; enb_s <= '1; enb_d <= '1;
    end else begin
      seg_m <= i_seg;     seg_s <= seg_m;
      dp_m  <= i_seg_dp;  dp_s  <= dp_m;
      enb_m <= i_seg_enb; enb_s <= enb_m; enb_d <= enb_s;
    end
  end

  assign changed = (enb_s != enb_d);
  assign legal   = $onehot(~enb_s);
  // Firing on the transition into saturation gives exactly one sample per dwell.
  assign sample  = !changed && (settle_cnt == SETTLE_LAST) && legal;
  assign timeout = !changed && (idle_cnt == IDLE_LAST);

  always_comb begin
    k = '0;
    for (int unsigned i = 0; i < 6; i++)
      if (!enb_s[i]) k = i[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      idle_cnt   <= '0;
    end else if (changed) begin
      settle_cnt <= '0;
      idle_cnt   <= '0;
    end else begin
      if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;
      if (idle_cnt != IDLE_MAX)     idle_cnt   <= idle_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) dec[i] = seg_dec(seg_q[i]);
    frame_ok = (seen == 6'h3F) && (seg_q[4] == 7'h00) && (seg_q[5] == 7'h00);
    for (int unsigned i = 0; i < 4; i++)
      if (dec[i][5:4] != 2'b10) frame_ok = 1'b0;
    if (dec[1][3:0] > 4'd5 || dec[3][3:0] > 4'd5) frame_ok = 1'b0;
    sec_w = {3'b0, dec[1][3:0]} * 7'd10 + {3'b0, dec[0][3:0]};
    min_w = {3'b0, dec[3][3:0]} * 7'd10 + {3'b0, dec[2][3:0]};
  end

`ifdef SEG_SCAN_CAPTURE_DOUBLE_CHECK_EN
  logic [15:0] cand_dig;
  logic [5:0]  cand_dp;
  logic        cand_vld;
  logic        cand_match;
  assign cand_match = cand_vld && (cand_dp == dp_q) &&
                      (cand_dig == {dec[3][3:0], dec[2][3:0], dec[1][3:0], dec[0][3:0]});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SYNC; next_k <= '0; seen <= '0; dp_q <= '0;
      for (int unsigned i = 0; i < 6; i++) seg_q[i] <= '0;
      o_min <= '0; o_sec <= '0; o_dp <= '0;
      o_frame_valid <= 1'b0; o_frame_err <= 1'b0; o_stale <= 1'b0;
`ifdef SEG_SCAN_CAPTURE_DOUBLE_CHECK_EN
      cand_dig <= '0; cand_dp <= '0; cand_vld <= 1'b0;
`endif
    end else begin
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      if (timeout) begin
        state   <= SYNC;
        seen    <= '0;
        o_stale <= 1'b1;
`ifdef SEG_SCAN_CAPTURE_DOUBLE_CHECK_EN
        cand_vld <= 1'b0;
`endif
      end else if (sample) begin
        if (state == COLLECT && k == next_k) begin
          seg_q[k]   <= seg_s;
          dp_q[k]    <= dp_s;
          seen[k]    <= 1'b1;
          next_k     <= next_k + 1'b1;
          if (k == 3'd5) state <= EMIT;
        end else begin
          // Out-of-order digit in COLLECT is an error; digit 0 always (re)starts a frame.
          if (state == COLLECT) o_frame_err <= 1'b1;
          if (k == 3'd0) begin
            seg_q[0] <= seg_s;
            dp_q[0]  <= dp_s;
            seen     <= 6'b000001;
            next_k   <= 3'd1;
            state    <= COLLECT;
          end else begin
            seen  <= '0;
            state <= SYNC;
          end
        end
      end else if (state == EMIT) begin
        state <= SYNC;
        seen  <= '0;
        if (frame_ok) begin
`ifdef SEG_SCAN_CAPTURE_DOUBLE_CHECK_EN
          cand_dig <= {dec[3][3:0], dec[2][3:0], dec[1][3:0], dec[0][3:0]};
          cand_dp  <= dp_q;
          cand_vld <= 1'b1;
          if (cand_match) begin
            o_min <= min_w[5:0]; o_sec <= sec_w[5:0]; o_dp <= dp_q;
            o_frame_valid <= 1'b1;
            o_stale       <= 1'b0;
          end
`else
          o_min <= min_w[5:0]; o_sec <= sec_w[5:0]; o_dp <= dp_q;
          o_frame_valid <= 1'b1;
          o_stale       <= 1'b0;
`endif
        end else begin
          o_frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture; scans hand-built frames and checks decoded outputs and pulses.
module tb_seg_scan_capture;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned TMO    = 1000;
  localparam int unsigned DWELL  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = '0;
  logic       dp  = 1'b0;
  logic [5:0] enb = '1;
  logic [5:0] o_min, o_sec, o_dp;
  logic       o_frame_valid, o_frame_err, o_stale;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int n_valid = 0, n_err = 0;
  int v0, e0;

  logic [6:0] lut [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                            7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

  always #5 clk = ~clk;

  seg_scan_capture #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .i_seg(seg), .i_seg_dp(dp), .i_seg_enb(enb),
    .o_min(o_min), .o_sec(o_sec), .o_dp(o_dp),
    .o_frame_valid(o_frame_valid), .o_frame_err(o_frame_err), .o_stale(o_stale)
  );

  always @(negedge clk) begin
    if (o_frame_valid) n_valid++;
    if (o_frame_err)   n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic show(input int k, input logic [6:0] p, input logic d, input int cyc);
    enb = ~(6'b000001 << k);
    seg = p;
    dp  = d;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic gap(input int cyc);
    enb = '1; seg = '0; dp = 1'b0;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] p3, p2, p1, p0, input logic [5:0] dm, input bit glitch);
    show(0, p0, dm[0], DWELL);
    show(1, p1, dm[1], DWELL);
    if (glitch) begin
      show(2, p2, dm[2], 4);
      show(3, p3, dm[3], 8);
    end
    show(2, p2, dm[2], DWELL);
    show(3, p3, dm[3], DWELL);
    show(4, 7'h00, dm[4], DWELL);
    show(5, 7'h00, dm[5], DWELL);
    gap(10);
  endtask

  task automatic scan_good(input logic [6:0] p3, p2, p1, p0, input logic [5:0] dm, input bit glitch);
`ifdef SEG_SCAN_CAPTURE_DOUBLE_CHECK_EN
    scan(p3, p2, p1, p0, dm, glitch);
`endif
    scan(p3, p2, p1, p0, dm, glitch);
  endtask

  task automatic snap();
    v0 = n_valid;
    e0 = n_err;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_min", o_min, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sec", o_sec, 0);
    check("rst_dp", o_dp, 0);
    check("rst_valid", o_frame_valid, 0);
    check("rst_err", o_frame_err, 0);
    check("rst_stale", o_stale, 0);
    gap(10);

    // 12:34, dp on digit 1
    snap();
    scan_good(lut[1], lut[2], lut[3], lut[4], 6'b000010, 1'b0);
    check("s1234_valid", n_valid - v0, 1);
    check("s1234_err", n_err - e0, 0);
    check("s1234_min", o_min, 12);
    check("s1234_sec", o_sec, 34);
    check("s1234_dp", o_dp, 6'b000010);

    // digit order 0,1,3
    snap();
    show(0, lut[9], 1'b0, DWELL);
    show(1, lut[5], 1'b0, DWELL);
    show(3, lut[5], 1'b0, DWELL);
    gap(10);
    check("order_err", n_err - e0, 1);
    check("order_valid", n_valid - v0, 0);
    check("order_min_hold", o_min, 12);
    check("order_sec_hold", o_sec, 34);

    snap();
    scan_good(lut[5], lut[9], lut[5], lut[9], 6'b000000, 1'b0);
    check("s5959_valid", n_valid - v0, 1);
    check("s5959_err", n_err - e0, 0);
    check("s5959_min", o_min, 59);
    check("s5959_sec", o_sec, 59);
    check("s5959_dp", o_dp, 0);

    // illegal pattern on digit 2
    snap();
    scan(lut[1], 7'h01, lut[2], lut[3], 6'b000000, 1'b0);
    check("illeg_err", n_err - e0, 1);
    check("illeg_valid", n_valid - v0, 0);
    check("illeg_min_hold", o_min, 59);

    // seconds tens digit 7
    snap();
    scan(lut[1], lut[2], lut[7], lut[3], 6'b000000, 1'b0);
    check("tens_err", n_err - e0, 1);
    check("tens_valid", n_valid - v0, 0);
    check("tens_sec_hold", o_sec, 59);

    // short digit-3 glitch inside digit 2's dwell
    snap();
    scan_good(lut[2], lut[3], lut[4], lut[5], 6'b000101, 1'b1);
    check("glitch_err", n_err - e0, 0);
    check("glitch_valid", n_valid - v0, 1);
    check("glitch_min", o_min, 23);
    check("glitch_sec", o_sec, 45);
    check("glitch_dp", o_dp, 6'b000101);

    // stale timeout while the bus sits blank
    check("stale_pre", o_stale, 0);
    repeat (TMO - 100) @(negedge clk);
    check("stale_before_limit", o_stale, 0);
    repeat (200) @(negedge clk);
    check("stale_set", o_stale, 1);
    check("stale_min_hold", o_min, 23);
    check("stale_sec_hold", o_sec, 45);

    snap();
    scan_good(lut[0], lut[0], lut[0], lut[0], 6'b000000, 1'b0);
    check("s0000_valid", n_valid - v0, 1);
    check("s0000_stale", o_stale, 0);
    check("s0000_min", o_min, 0);
    check("s0000_sec", o_sec, 0);

    // reset mid-frame after digit 2 of 08:15 was taken
    scan_good(lut[4], lut[3], lut[2], lut[1], 6'b001000, 1'b0);
    check("pre_rst_min", o_min, 43);
    snap();
    show(0, lut[5], 1'b0, DWELL);
    show(1, lut[1], 1'b0, DWELL);
    show(2, lut[8], 1'b0, DWELL);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    gap(10);
    check("mid_rst_min", o_min, 0);
    check("mid_rst_sec", o_sec, 0);
    check("mid_rst_dp", o_dp, 0);
    check("mid_rst_valid", n_valid - v0, 0);
    check("mid_rst_err", n_err - e0, 0);

    snap();
`ifdef SEG_SCAN_CAPTURE_DOUBLE_CHECK_EN
    scan(lut[0], lut[8], lut[1], lut[5], 6'b000000, 1'b0);
    check("dbl_first_valid", n_valid - v0, 0);
    check("dbl_first_min", o_min, 0);
    scan(lut[0], lut[8], lut[1], lut[5], 6'b000000, 1'b0);
`else
    scan(lut[0], lut[8], lut[1], lut[5], 6'b000000, 1'b0);
`endif
    check("s0815_valid", n_valid - v0, 1);
    check("s0815_err", n_err - e0, 0);
    check("s0815_min", o_min, 8);
    check("s0815_sec", o_sec, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
